// File: rtl/inverse_interpolation.sv
// rtl/inverse_interpolation.sv - inverse linear interpolation: x from y via shift-add multiply and restoring divide
module inverse_interpolation #(
  parameter int DATA_WIDTH = 128,
  parameter int FRAC_BITS  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [DATA_WIDTH-1:0]                pt0,
  input  logic [DATA_WIDTH-1:0]                pt1,
  input  logic [DATA_WIDTH/2-1:0]              y_in,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [DATA_WIDTH/2+FRAC_BITS-1:0]    x_out
);

  localparam int HW    = DATA_WIDTH / 2;
  localparam int QW    = HW + FRAC_BITS;
  localparam int CNT_W = $clog2(QW);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV, S_FIN} state_t;

  state_t state, state_next;

  logic [HW-1:0]    x0_r, y0_r, x1_r, y1_r, yq_r;
  logic [HW-1:0]    dy_r;
  logic             err_flag_r;
  logic [HW-1:0]    err_val_r;
  logic [2*HW-1:0]  mul_acc, mul_mcand;
  logic [HW-1:0]    mul_mplier;
  logic [HW-1:0]    div_rem;
  logic [QW-1:0]    div_sh;
  logic [CNT_W-1:0] cnt;

  logic [HW-1:0]    dx_c, dy_c, dn_c, prep_val;
  logic             y_up, beyond_y0, beyond_y1, prep_err;
  logic [2*HW-1:0]  acc_next;
  logic [HW:0]      trial;
  logic             div_ge;
  logic [HW-1:0]    rem_next;

  assign busy = (state != S_IDLE);

  // Segment geometry and error classification, evaluated from the latched operands in PREP.
  always_comb begin
    dx_c      = x1_r - x0_r;
    y_up      = (y1_r >= y0_r);
    dy_c      = y_up ? (y1_r - y0_r) : (y0_r - y1_r);
    dn_c      = (yq_r >= y0_r) ? (yq_r - y0_r) : (y0_r - yq_r);
    beyond_y0 = y_up ? (yq_r < y0_r) : (yq_r > y0_r);
    beyond_y1 = y_up ? (yq_r > y1_r) : (yq_r < y1_r);
    prep_err  = 1'b0;
    prep_val  = x0_r;
    if (x1_r < x0_r) begin
      prep_err = 1'b1;
    end else if (dy_c == '0) begin
      prep_err = 1'b1;
    end else if (beyond_y0) begin
      prep_err = 1'b1;
    end else if (beyond_y1) begin
      prep_err = 1'b1;
      prep_val = x1_r;
    end
  end

  // Remainder stays below dy, so the low HW bits of the modular subtraction are exact.
  always_comb begin
    acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    trial    = {div_rem, div_sh[QW-1]};
    div_ge   = (trial >= {1'b0, dy_r});
    rem_next = div_ge ? (trial[HW-1:0] - dy_r) : trial[HW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_PREP;
      S_PREP: state_next = prep_err ? S_FIN : S_MUL;
      S_MUL:  if (cnt == CNT_W'(HW - 1)) state_next = S_DIV;
      S_DIV:  if (cnt == CNT_W'(QW - 1)) state_next = S_FIN;
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_r       <= '0;
      y0_r       <= '0;
      x1_r       <= '0;
      y1_r       <= '0;
      yq_r       <= '0;
      dy_r       <= '0;
      err_flag_r <= 1'b0;
      err_val_r  <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      div_rem    <= '0;
      div_sh     <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      x_out      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x0_r <= pt0[DATA_WIDTH-1:HW];
            y0_r <= pt0[HW-1:0];
            x1_r <= pt1[DATA_WIDTH-1:HW];
            y1_r <= pt1[HW-1:0];
            yq_r <= y_in;
          end
        end
        S_PREP: begin
          dy_r       <= dy_c;
          mul_acc    <= '0;
          mul_mcand  <= {{HW{1'b0}}, dx_c};
          mul_mplier <= dn_c;
          cnt        <= '0;
          err_flag_r <= prep_err;
          err_val_r  <= prep_val;
        end
        S_MUL: begin
          mul_acc    <= acc_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          if (cnt == CNT_W'(HW - 1)) begin
            // Upper quotient bits are provably zero, so the top half of P seeds the remainder.
            cnt     <= '0;
            div_rem <= acc_next[2*HW-1:HW];
            div_sh  <= {acc_next[HW-1:0], {FRAC_BITS{1'b0}}};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          div_rem <= rem_next;
          div_sh  <= {div_sh[QW-2:0], div_ge};
          cnt     <= cnt + CNT_W'(1);
        end
        S_FIN: begin
          done <= 1'b1;
          err  <= err_flag_r;
          if (err_flag_r) x_out <= {err_val_r, {FRAC_BITS{1'b0}}};
          else            x_out <= {x0_r, {FRAC_BITS{1'b0}}} + div_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_interpolation.sv
// tb/tb_inverse_interpolation.sv - directed and reference-model bench for inverse_interpolation
module tb_inverse_interpolation;

  localparam int DW = 128;
  localparam int HW = 64;
  localparam int FB = 16;
  localparam int QW = HW + FB;
  localparam int NORM_LAT = 2 * HW + FB + 2;
  localparam int ERR_LAT = 2;
  localparam int MAX_WAIT = 300;

  typedef struct {
    logic [HW-1:0] x0, y0, x1, y1, y;
    logic [QW-1:0] ex;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pt0 = '0;
  logic [DW-1:0] pt1 = '0;
  logic [HW-1:0] y_in = '0;
  logic          busy, done, err;
  logic [QW-1:0] x_out;

  int n_pass = 0;
  int n_checks = 0;

  inverse_interpolation #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pt0(pt0), .pt1(pt1),
    .y_in(y_in), .busy(busy), .done(done), .err(err), .x_out(x_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pk(input logic [HW-1:0] x, input logic [HW-1:0] y);
    return {x, y};
  endfunction

  function automatic void ref_model(input logic [HW-1:0] x0, y0, x1, y1, y,
                                    output logic [QW-1:0] ex, output logic ee);
    logic [HW-1:0]  lo, hi, dn;
    logic [159:0]   num;
    logic [159:0]   q;
    ee = 1'b0;
    ex = '0;
    lo = (y0 < y1) ? y0 : y1;
    hi = (y0 < y1) ? y1 : y0;
    if (x1 < x0 || y0 == y1) begin
      ee = 1'b1;
      ex = {x0, {FB{1'b0}}};
    end else if (y < lo || y > hi) begin
      ee = 1'b1;
      ex = ((y < lo) == (y0 < y1)) ? {x0, {FB{1'b0}}} : {x1, {FB{1'b0}}};
    end else begin
      dn  = (y >= y0) ? y - y0 : y0 - y;
      num = (160'(dn) * 160'(x1 - x0)) << FB;
      q   = num / 160'(hi - lo);
      ex  = {x0, {FB{1'b0}}} + q[QW-1:0];
    end
  endfunction

  // Call at a negedge; returns at the negedge where done is seen (or after MAX_WAIT edges).
  task automatic run_op(input logic [DW-1:0] p0, input logic [DW-1:0] p1, input logic [HW-1:0] y,
                        output int lat, output int busy_cyc);
    pt0 = p0;
    pt1 = p1;
    y_in = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    n_checks++; if (x_out !== '0) $display("FAIL reset_x got %h exp 0", x_out); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_ascending();
    int lat, bc;
    run_op(pk(0, 0), pk(10, 100), 64'd50, lat, bc);
    n_checks++; if (lat !== NORM_LAT) $display("FAIL asc_latency got %0d exp %0d", lat, NORM_LAT); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL asc_err got %b exp 0", err); else n_pass++;
    n_checks++; if (x_out !== 80'h50000) $display("FAIL asc_x got %h exp 50000", x_out); else n_pass++;
    n_checks++; if (bc !== NORM_LAT) $display("FAIL asc_busy_cycles got %0d exp %0d", bc, NORM_LAT); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL asc_done_width got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_descending();
    vec_t v[4];
    int lat, bc;
    v[0] = '{x0: 64'd10, y0: 64'd200, x1: 64'd20, y1: 64'd100, y: 64'd150, ex: 80'hF0000};
    v[1] = '{x0: 64'd0,  y0: 64'd0,   x1: 64'd1,  y1: 64'd3,   y: 64'd1,   ex: 80'h5555};
    v[2] = '{x0: 64'd10, y0: 64'd200, x1: 64'd20, y1: 64'd100, y: 64'd200, ex: 80'hA0000};
    v[3] = '{x0: 64'd10, y0: 64'd200, x1: 64'd20, y1: 64'd100, y: 64'd100, ex: 80'h140000};
    for (int i = 0; i < 4; i++) begin
      run_op(pk(v[i].x0, v[i].y0), pk(v[i].x1, v[i].y1), v[i].y, lat, bc);
      n_checks++; if (lat !== NORM_LAT) $display("FAIL desc%0d_latency got %0d exp %0d", i, lat, NORM_LAT); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL desc%0d_err got %b exp 0", i, err); else n_pass++;
      n_checks++; if (x_out !== v[i].ex) $display("FAIL desc%0d_x got %h exp %h", i, x_out, v[i].ex); else n_pass++;
    end
  endtask

  task automatic test_errors();
    vec_t v[4];
    int lat, bc;
    v[0] = '{x0: 64'd3,  y0: 64'd7,  x1: 64'd5,  y1: 64'd7,   y: 64'd7,   ex: 80'h30000};
    v[1] = '{x0: 64'd0,  y0: 64'd0,  x1: 64'd10, y1: 64'd100, y: 64'd250, ex: 80'hA0000};
    v[2] = '{x0: 64'd20, y0: 64'd0,  x1: 64'd10, y1: 64'd100, y: 64'd50,  ex: 80'h140000};
    v[3] = '{x0: 64'd5,  y0: 64'd50, x1: 64'd9,  y1: 64'd100, y: 64'd10,  ex: 80'h50000};
    for (int i = 0; i < 4; i++) begin
      run_op(pk(v[i].x0, v[i].y0), pk(v[i].x1, v[i].y1), v[i].y, lat, bc);
      n_checks++; if (lat !== ERR_LAT) $display("FAIL err%0d_latency got %0d exp %0d", i, lat, ERR_LAT); else n_pass++;
      n_checks++; if (err !== 1'b1) $display("FAIL err%0d_flag got %b exp 1", i, err); else n_pass++;
      n_checks++; if (x_out !== v[i].ex) $display("FAIL err%0d_x got %h exp %h", i, x_out, v[i].ex); else n_pass++;
    end
  endtask

  task automatic test_handshake();
    int n, dones, first_lat;
    logic [QW-1:0] got_x;
    logic got_e;
    dones = 0;
    first_lat = -1;
    got_x = '0;
    got_e = 1'b1;
    pt0 = pk(0, 0);
    pt1 = pk(10, 100);
    y_in = 64'd50;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 10) begin
        pt0 = pk(99, 1);
        pt1 = pk(200, 2);
        y_in = 64'd3;
        start = 1'b1;
      end else if (n == 11) begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_lat = n;
          got_x = x_out;
          got_e = err;
        end
      end
    end
    n_checks++; if (dones !== 1) $display("FAIL hs_done_count got %0d exp 1", dones); else n_pass++;
    n_checks++; if (first_lat !== NORM_LAT) $display("FAIL hs_latency got %0d exp %0d", first_lat, NORM_LAT); else n_pass++;
    n_checks++; if (got_x !== 80'h50000) $display("FAIL hs_x got %h exp 50000", got_x); else n_pass++;
    n_checks++; if (got_e !== 1'b0) $display("FAIL hs_err got %b exp 0", got_e); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL hs_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(pk(0, 0), pk(10, 100), 64'd50, lat, bc);
    n_checks++; if (x_out !== 80'h50000) $display("FAIL b2b_first_x got %h exp 50000", x_out); else n_pass++;
    run_op(pk(10, 200), pk(20, 100), 64'd150, lat, bc);
    n_checks++; if (lat !== NORM_LAT) $display("FAIL b2b_latency got %0d exp %0d", lat, NORM_LAT); else n_pass++;
    n_checks++; if (x_out !== 80'hF0000) $display("FAIL b2b_second_x got %h exp f0000", x_out); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge clk);
    pt0 = pk(0, 0);
    pt1 = pk(10, 100);
    y_in = 64'd50;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rmid_done got %b exp 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rmid_err got %b exp 0", err); else n_pass++;
    n_checks++; if (x_out !== '0) $display("FAIL rmid_x got %h exp 0", x_out); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(pk(0, 0), pk(10, 100), 64'd50, lat, bc);
    n_checks++; if (lat !== NORM_LAT) $display("FAIL rmid_latency got %0d exp %0d", lat, NORM_LAT); else n_pass++;
    n_checks++; if (x_out !== 80'h50000) $display("FAIL rmid_x_after got %h exp 50000", x_out); else n_pass++;
  endtask

  task automatic test_extreme();
    int lat, bc;
    logic [QW-1:0] ex;
    ex = '0;
    ex[79] = 1'b1;
    run_op(pk(64'd0, 64'd0), pk({64{1'b1}}, {64{1'b1}}), 64'h8000_0000_0000_0000, lat, bc);
    n_checks++; if (lat !== NORM_LAT) $display("FAIL ext_latency got %0d exp %0d", lat, NORM_LAT); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL ext_err got %b exp 0", err); else n_pass++;
    n_checks++; if (x_out !== ex) $display("FAIL ext_x got %h exp %h", x_out, ex); else n_pass++;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [HW-1:0] a, b, c, t, xa, xb, x0, x1, y0, y1;
    logic [QW-1:0] ex;
    logic ee;
    for (int i = 0; i < 8; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      c  = {$urandom, $urandom};
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      if (a > b) begin t = a; a = b; b = t; end
      if (b > c) begin t = b; b = c; c = t; end
      if (a > b) begin t = a; a = b; b = t; end
      x0 = (xa < xb) ? xa : xb;
      x1 = (xa < xb) ? xb : xa;
      y0 = i[0] ? c : a;
      y1 = i[0] ? a : c;
      ref_model(x0, y0, x1, y1, b, ex, ee);
      run_op(pk(x0, y0), pk(x1, y1), b, lat, bc);
      n_checks++; if (x_out !== ex) $display("FAIL rand%0d_x got %h exp %h", i, x_out, ex); else n_pass++;
      n_checks++; if (err !== ee) $display("FAIL rand%0d_err got %b exp %b", i, err, ee); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_errors();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_extreme();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inverse_interpolation.md
Name: inverse_interpolation

Overview:
- Inverse of the forward linear-interpolation datapath. Given two calibration points (x0,y0) and (x1,y1) and a query ordinate y, it computes x = x0 + |y-y0|*(x1-x0)/|y1-y0|.
- The result is fixed-point with FRAC_BITS fractional bits, produced by a multi-cycle shift-add multiplier followed by a restoring divider.
- It sits beside the forward interpolator in the curve-lookup datapath and uses the same packed point format, {x, y}, with x in the upper half of the word and y in the lower half.

Parameters:
- DATA_WIDTH, 128: packed point width. HW = DATA_WIDTH/2 = 64 bits per coordinate.
- FRAC_BITS, 16: fractional bits in x_out.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: request pulse; sampled only in IDLE.
- pt0, input, DATA_WIDTH: {x0[HW-1:0], y0[HW-1:0]}.
- pt1, input, DATA_WIDTH: {x1, y1}.
- y_in, input, HW: query ordinate; unsigned.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle result-valid pulse.
- err, output, 1: result status, valid from the done pulse onward.
- x_out, output, HW+FRAC_BITS: result, unsigned fixed-point, integer part in [HW+FRAC_BITS-1:FRAC_BITS].

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0, x_out=0. Counters and datapath registers are cleared. Reset mid-operation abandons the computation silently, with no done pulse.
- Input capture: on the edge where state=IDLE and start=1, pt0, pt1 and y_in are latched into internal registers. Inputs may change freely afterwards. start while busy=1 is ignored.
- All arithmetic is unsigned.
- States:
  - IDLE -> PREP on start.
  - PREP, 1 cycle. Computes dx=x1-x0, dy=|y1-y0|, dn=|y-y0|, and checks error conditions in priority order:
    (a) x1<x0 -> err, result x0.
    (b) dy==0 -> err, result x0.
    (c) y outside [min(y0,y1), max(y0,y1)] -> err, result clamped to the x of the nearer endpoint (x0 if y is beyond y0, x1 if beyond y1).
    Any error -> FIN. Otherwise -> MUL.
  - MUL, HW cycles. Shift-add multiply computes P = dn*dx (2*HW bits), one multiplier bit per cycle, counter 0..HW-1, then -> DIV.
  - DIV, HW+FRAC_BITS cycles. Restoring division of (P << FRAC_BITS) by dy produces one quotient bit per cycle, MSB first.
    - Remainder register is HW+1 bits; compare is remainder >= dy; on success, subtract and shift in 1, else shift in 0.
    - The quotient is truncated (floor); no rounding.
    - Because dn<=dy, Q <= dx<<FRAC_BITS, so the quotient fits in HW+FRAC_BITS bits. Upper dividend bits that are provably zero may be skipped, but the cycle count is fixed.
    - -> FIN.
  - FIN, 1 cycle. On the exit edge:
    - x_out <= (x0<<FRAC_BITS) + Q on the normal path, or the error value << FRAC_BITS on the error path.
    - err is set accordingly.
    - done <= 1 for exactly one cycle.
    - -> IDLE.
- Latency, counting the start-sampling edge as edge 0:
  - Normal: done is high after edge 2*HW+FRAC_BITS+2 (edge 146 at defaults).
  - Error: done is high after edge 2.
  - busy goes high after edge 0 and low on the same edge that raises done.
- x_out and err hold their value until the next FIN, and are unchanged by a new start.
- A back-to-back start may be sampled in the cycle done is high, because the state is IDLE then.
- No overflow is possible on x_out: x0 + (x1-x0) <= 2^HW-1.

Test Plan:
1. Ascending segment: pt0={0,0}, pt1={10,100}, y_in=50 -> done at edge 146, err=0, x_out=0x50000 (5.0). busy is high over exactly 146 cycles.
2. Descending segment and fraction:
   - pt0={10,200}, pt1={20,100}, y_in=150 -> x_out=0xF0000, err=0.
   - pt0={0,0}, pt1={1,3}, y_in=1 -> x_out=0x5555 (floor of 1/3).
   - Endpoints: y_in=y0 -> x0<<16; y_in=y1 -> x1<<16.
3. Errors, each with done at edge 2 and err=1:
   - y0=y1=7, y_in=7 -> x_out=x0<<16.
   - pt0={0,0}, pt1={10,100}, y_in=250 -> x_out=10<<16.
   - x1<x0 -> x_out=x0<<16.
4. Handshake:
   - Change pt0/pt1/y_in and pulse start during busy -> result still matches the originally latched operands, with exactly one done pulse.
   - Start asserted in the done cycle -> second result follows 146 edges later.
5. Reset mid-operation: assert reset_n=0 asynchronously at cycle 70 of a computation -> busy, done, err and x_out all 0 immediately. A fresh start after release yields the correct result with full latency.
6. Extreme widths: x0=0, x1=2^64-1, y0=0, y1=2^64-1, y_in=2^63 -> x_out=2^63<<16, no overflow. Random ascending and descending vectors are compared against a floor-division reference model.
